// File: rtl/sd_spi_responder_if.sv
// rtl/sd_spi_responder_if.sv - SPI-mode SD bus between host and sd_spi_responder
// The host drives sclk/mosi/ss; the responder drives miso and the decoded-command outputs.
interface sd_spi_responder_if;
  logic        sclk;
  logic        mosi;
  logic        ss;
  logic        miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        in_idle;

  modport master (
    output sclk, mosi, ss,
    input  miso, cmd_valid, cmd_index, cmd_arg, in_idle
  );

  modport slave (
    input  sclk, mosi, ss,
    output miso, cmd_valid, cmd_index, cmd_arg, in_idle
  );
endinterface

// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SD SPI-mode command receiver returning an R1 response
// Optional CRC7 frame check is compiled in when SD_SPI_RESPONDER_CRC_CHECK_EN is defined.
module sd_spi_responder #(
  parameter int NCR         = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  sd_spi_responder_if.slave bus
);

  typedef enum logic [1:0] {HUNT, CMD, FILL, RESP} state_t;

  localparam logic [6:0] FILL_LAST = 7'(8 * NCR - 1);
  localparam logic [6:0] RESP_BITS = 7'd8;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   sclk_rise;
  logic                   sclk_fall;

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  // Holds frame bits 45..1 once bit 48 arrives; start/transmission bits are implied.
  logic [44:0] shift_q, shift_d;
  logic [6:0]  fall_cnt_q, fall_cnt_d;
  logic [7:0]  r1_q, r1_d;
  logic        miso_q, miso_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic        in_idle_q, in_idle_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '1;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q[0] <= bus.sclk;
      mosi_sync_q[0] <= bus.mosi;
      ss_sync_q[0]   <= bus.ss;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
        ss_sync_q[i]   <= ss_sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

`ifdef SD_SPI_RESPONDER_CRC_CHECK_EN
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  logic crc_bad;
  assign crc_bad = crc7({2'b01, shift_q[44:7]}) != shift_q[6:0];
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    fall_cnt_d  = fall_cnt_q;
    r1_d        = r1_q;
    miso_d      = miso_q;
    cmd_valid_d = 1'b0;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    in_idle_d   = in_idle_q;

    if (ss_s) begin
      state_d    = HUNT;
      miso_d     = 1'b1;
      bit_cnt_d  = '0;
      fall_cnt_d = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (sclk_fall) miso_d = 1'b1;
          if (sclk_rise && !mosi_s) begin
            state_d   = CMD;
            bit_cnt_d = 6'd1;
          end
        end

        CMD: begin
          if (sclk_rise) begin
            shift_d   = {shift_q[43:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd1 && !mosi_s) begin
              state_d   = HUNT;
              bit_cnt_d = '0;
            end else if (bit_cnt_q == 6'd47) begin
              // mosi_s is the stop bit; shift_q already carries bits 45..1.
              bit_cnt_d = '0;
              if (!mosi_s) begin
                state_d = HUNT;
              end else begin
                state_d     = FILL;
                fall_cnt_d  = '0;
                cmd_valid_d = 1'b1;
                cmd_index_d = shift_q[44:39];
                cmd_arg_d   = shift_q[38:7];
                case (shift_q[44:39])
                  6'd0: begin
                    r1_d      = 8'h01;
                    in_idle_d = 1'b1;
                  end
                  6'd1: begin
                    r1_d      = 8'h00;
                    in_idle_d = 1'b0;
                  end
                  default: r1_d = {5'b0, 1'b1, 1'b0, in_idle_q};
                endcase
`ifdef SD_SPI_RESPONDER_CRC_CHECK_EN
                if (crc_bad) begin
                  r1_d      = {4'b0, 1'b1, 2'b0, in_idle_q};
                  in_idle_d = in_idle_q;
                end
`endif
              end
            end
          end
        end

        FILL: begin
          if (sclk_fall) begin
            miso_d = 1'b1;
            if (fall_cnt_q == FILL_LAST) begin
              state_d    = RESP;
              fall_cnt_d = '0;
            end else begin
              fall_cnt_d = fall_cnt_q + 7'd1;
            end
          end
        end

        RESP: begin
          // Eight falls shift R1 out MSB first; the ninth fall releases miso.
          if (sclk_fall) begin
            if (fall_cnt_q == RESP_BITS) begin
              miso_d     = 1'b1;
              state_d    = HUNT;
              fall_cnt_d = '0;
            end else begin
              miso_d     = r1_q[7];
              r1_d       = {r1_q[6:0], 1'b0};
              fall_cnt_d = fall_cnt_q + 7'd1;
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      fall_cnt_q  <= '0;
      r1_q        <= '0;
      miso_q      <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
      in_idle_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      fall_cnt_q  <= fall_cnt_d;
      r1_q        <= r1_d;
      miso_q      <= miso_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      in_idle_q   <= in_idle_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_index = cmd_index_q;
  assign bus.cmd_arg   = cmd_arg_q;
  assign bus.in_idle   = in_idle_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - directed and randomized bench for sd_spi_responder
// Builds with or without SD_SPI_RESPONDER_CRC_CHECK_EN; the reference model follows the same define.
module tb_sd_spi_responder;
  localparam int NCR  = 1;
  localparam int HALF = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   valid_cnt = 0;

  logic        model_idle;
  logic [5:0]  model_index;
  logic [31:0] model_arg;

  sd_spi_responder_if bus();

  sd_spi_responder #(.NCR(NCR), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.cmd_valid === 1'b1) valid_cnt <= valid_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC7 as the remainder of polynomial long division by x^7+x^3+1.
  function automatic logic [6:0] crc_ref(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, crc_ref(body), 1'b1};
  endfunction

  task automatic model_frame(input logic [47:0] f, output logic ok, output logic [7:0] r1);
    ok = (f[47:46] == 2'b01) && f[0];
    r1 = 8'hFF;
    if (ok) begin
      model_index = f[45:40];
      model_arg   = f[39:8];
`ifdef SD_SPI_RESPONDER_CRC_CHECK_EN
      if (crc_ref(f[47:8]) != f[7:1]) begin
        r1 = 8'h08 + 8'(model_idle);
        return;
      end
`endif
      if (f[45:40] == 6'd0) begin
        model_idle = 1'b1;
        r1 = 8'h01;
      end else if (f[45:40] == 6'd1) begin
        model_idle = 1'b0;
        r1 = 8'h00;
      end else begin
        r1 = 8'h04 + 8'(model_idle);
      end
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    bus.mosi = b;
    wait_clk(HALF);
    m = bus.miso;
    bus.sclk = 1'b1;
    wait_clk(HALF);
    bus.sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic run_frame(input string tag, input logic [47:0] f);
    logic [7:0] rx, r1_obs, tail, r1_exp;
    logic       pre_ok, valid_exp;
    int         v0;
    v0 = valid_cnt;
    model_frame(f, valid_exp, r1_exp);
    bus.ss = 1'b0;
    pre_ok = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      spi_byte(f[i*8 +: 8], rx);
      if (rx !== 8'hFF) pre_ok = 1'b0;
    end
    for (int i = 0; i < NCR; i++) begin
      spi_byte(8'hFF, rx);
      if (rx !== 8'hFF) pre_ok = 1'b0;
    end
    spi_byte(8'hFF, r1_obs);
    spi_byte(8'hFF, tail);
    bus.ss = 1'b1;
    wait_clk(4 * HALF);
    check({tag, ".miso_high_before_r1"}, 64'(pre_ok), 64'd1);
    check({tag, ".r1"}, 64'(r1_obs), 64'(r1_exp));
    check({tag, ".miso_high_after_r1"}, 64'(tail), 64'hFF);
    check({tag, ".cmd_valid_pulses"}, 64'(valid_cnt - v0), 64'(valid_exp));
    check({tag, ".cmd_index"}, 64'(bus.cmd_index), 64'(model_index));
    check({tag, ".cmd_arg"}, 64'(bus.cmd_arg), 64'(model_arg));
    check({tag, ".in_idle"}, 64'(bus.in_idle), 64'(model_idle));
  endtask

  initial begin
    logic [47:0] f;
    logic [7:0]  rx;
    logic [5:0]  idx;
    logic        m, pre_ok;
    int          v0;

    bus.sclk = 1'b0;
    bus.mosi = 1'b1;
    bus.ss   = 1'b1;
    model_idle  = 1'b1;
    model_index = '0;
    model_arg   = '0;
    wait_clk(5);
    check("reset.miso", 64'(bus.miso), 64'd1);
    check("reset.cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check("reset.cmd_index", 64'(bus.cmd_index), 64'd0);
    check("reset.cmd_arg", 64'(bus.cmd_arg), 64'd0);
    check("reset.in_idle", 64'(bus.in_idle), 64'd1);
    rst_n = 1'b1;
    wait_clk(10);

    run_frame("cmd0", 48'h400000000095);
    run_frame("cmd5_idle", make_frame(6'd5, 32'h12345678));
    run_frame("cmd1", 48'h4100000000F9);
    run_frame("cmd5_ready", make_frame(6'd5, 32'h12345678));
    run_frame("cmd0_again", 48'h400000000095);
    run_frame("cmd0_bad_crc", 48'h400000000097);
    run_frame("bad_stop", 48'h400000000094);
    run_frame("bad_trans", 48'h3FFFFFFFFFFF);

    // Partial CMD0 aborted by ss, then a complete CMD1.
    v0 = valid_cnt;
    f = 48'h400000000095;
    bus.ss = 1'b0;
    pre_ok = 1'b1;
    for (int i = 47; i >= 28; i--) begin
      spi_bit(f[i], m);
      if (m !== 1'b1) pre_ok = 1'b0;
    end
    bus.ss = 1'b1;
    wait_clk(4 * HALF);
    check("abort.miso_high", 64'(pre_ok), 64'd1);
    check("abort.no_pulse", 64'(valid_cnt - v0), 64'd0);
    run_frame("abort_then_cmd1", 48'h4100000000F9);
    check("abort.total_pulses", 64'(valid_cnt - v0), 64'd1);

    for (int n = 0; n < 10; n++) begin
      idx = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 1)) : 6'($urandom_range(0, 63));
      f = make_frame(idx, 32'($urandom));
      if ($urandom_range(0, 4) == 0) f[1 + $urandom_range(0, 6)] ^= 1'b1;
      run_frame($sformatf("rand%0d", n), f);
    end

    // Reset while R1 of CMD1 is being shifted out.
    run_frame("pre_rst_cmd0", 48'h400000000095);
    f = 48'h4100000000F9;
    bus.ss = 1'b0;
    for (int i = 5; i >= 0; i--) spi_byte(f[i*8 +: 8], rx);
    for (int i = 0; i < NCR; i++) spi_byte(8'hFF, rx);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_resp.miso", 64'(bus.miso), 64'd1);
    check("rst_mid_resp.in_idle", 64'(bus.in_idle), 64'd1);
    check("rst_mid_resp.cmd_index", 64'(bus.cmd_index), 64'd0);
    bus.ss = 1'b1;
    wait_clk(4);
    v0 = valid_cnt;
    rst_n = 1'b1;
    wait_clk(40);
    check("rst_mid_resp.no_pulse", 64'(valid_cnt - v0), 64'd0);
    model_idle  = 1'b1;
    model_index = '0;
    model_arg   = '0;
    run_frame("post_rst_cmd0", 48'h400000000095);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
